// File: rtl/systolic_feeder_pkg.sv
// Shared constants and FSM encoding for the systolic operand feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package systolic_feeder_pkg;

   localparam int DEF_N  = 4;
   localparam int DEF_DW = 8;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/systolic_feeder_operand_buffer.sv
// NxN operand register file: one write port, N-lane diagonal read for skew index rd_k.
// Latency: write commits at the clock edge; read is combinational and forwards a same-cycle write.
// Backpressure: none; writes are gated by the owner.
module systolic_feeder_operand_buffer #(
   parameter int   N         = 4,
   parameter int   DW        = 8,
   parameter bit   COL_MAJOR = 1'b0,
   localparam int  IW        = $clog2(N),
   localparam int  KW        = $clog2(2 * N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [IW-1:0]   wr_row,
   input  logic [IW-1:0]   wr_col,
   input  logic [DW-1:0]   wr_data,
   input  logic [KW-1:0]   rd_k,
   output logic [N*DW-1:0] rd_data
);

   logic [DW-1:0] mem [N][N];

   // storage: cleared by reset, single write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem[r][c] <= '0;
            end
         end
      end else if (wr_en) begin
         mem[wr_row][wr_col] <= wr_data;
      end
   end

   // Lane l reads element (l, k-l) for A or (k-l, l) for B; outside the
   // diagonal the lane is zero. A write in the same cycle is forwarded so a
   // run started together with a write sees the new value.
   for (genvar l = 0; l < N; l++) begin : g_lane
      logic [KW:0]   diff;
      logic          in_rng;
      logic [IW-1:0] idx;
      logic [IW-1:0] row;
      logic [IW-1:0] col;
      logic          fwd;

      assign diff   = {1'b0, rd_k} - (KW+1)'(l);
      assign in_rng = !diff[KW] && (diff[KW-1:0] < KW'(N));
      assign idx    = diff[IW-1:0];
      assign row    = COL_MAJOR ? idx : IW'(l);
      assign col    = COL_MAJOR ? IW'(l) : idx;
      assign fwd    = wr_en && (wr_row == row) && (wr_col == col);
      assign rd_data[l*DW +: DW] = !in_rng ? '0 : (fwd ? wr_data : mem[row][col]);
   end

endmodule

// File: rtl/systolic_feeder.sv
// Streams buffered A rows / B columns into the systolic array edges with diagonal skew, then flushes.
// Latency: start at edge t -> first skewed operands at t+1; done pulse at t+3N-1.
// Backpressure: none; a run always completes, start and writes while busy are dropped.
module systolic_feeder
   import systolic_feeder_pkg::*;
#(
   parameter int  N  = DEF_N,
   parameter int  DW = DEF_DW,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [IW-1:0]   wr_row,
   input  logic [IW-1:0]   wr_col,
   input  logic [DW-1:0]   wr_data,
   input  logic            start,
   output logic [N*DW-1:0] a_edge,
   output logic [N*DW-1:0] b_edge,
   output logic            feed_vld,
   output logic            busy,
   output logic            done,
   output logic            wr_err
);

   localparam int KW = $clog2(2 * N);

   state_t         state;
   state_t         state_nxt;
   logic [KW-1:0]  cnt;
   logic [KW-1:0]  cnt_nxt;
   logic           in_range;
   logic           wr_ok;
   logic [N*DW-1:0] rd_a;
   logic [N*DW-1:0] rd_b;

   // Only checked against N so non-power-of-2 arrays reject the spare indices.
   assign in_range = ({1'b0, wr_row} < (IW+1)'(N)) && ({1'b0, wr_col} < (IW+1)'(N));
   assign wr_ok    = wr_en && (state == ST_IDLE) && in_range;

   systolic_feeder_operand_buffer #(.N(N), .DW(DW), .COL_MAJOR(1'b0)) u_buf_a (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok && (wr_sel == SEL_A)),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .rd_k    (cnt_nxt),
      .rd_data (rd_a)
   );

   systolic_feeder_operand_buffer #(.N(N), .DW(DW), .COL_MAJOR(1'b1)) u_buf_b (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_ok && (wr_sel == SEL_B)),
      .wr_row  (wr_row),
      .wr_col  (wr_col),
      .wr_data (wr_data),
      .rd_k    (cnt_nxt),
      .rd_data (rd_b)
   );

   // state register and shared skew/flush counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: FEED holds k = 0..2N-2, FLUSH counts N-1 cycles, DONE lasts one
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_FEED;
               cnt_nxt   = '0;
            end
         end
         ST_FEED: begin
            if (cnt == KW'(2 * N - 2)) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + KW'(1);
            end
         end
         ST_FLUSH: begin
            if (cnt == KW'(N - 2)) begin
               state_nxt = ST_DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + KW'(1);
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // outputs registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_edge   <= '0;
         b_edge   <= '0;
         feed_vld <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         a_edge   <= (state_nxt == ST_FEED) ? rd_a : '0;
         b_edge   <= (state_nxt == ST_FEED) ? rd_b : '0;
         feed_vld <= (state_nxt == ST_FEED);
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_DONE);
         wr_err   <= wr_en && !wr_ok;
      end
   end

endmodule
